// File: rtl/riscv_pkg.sv
// Shared integer-pipeline definitions: datapath sizes, register address type
// and the load funct3 encodings used by the writeback stage.
package riscv_pkg;

  localparam int XLEN     = 64;
  localparam int NUM_REGS = 32;
  localparam int CNT_W    = 2;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_D  = 3'b011,
    LD_BU = 3'b100,
    LD_HU = 3'b101,
    LD_WU = 3'b110
  } ld_funct3_e;

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of the issue, ALU-result, load-result and register-file write-port
// signals seen by the writeback stage. The slave side is the writeback block.
interface regfile_writeback_if;
  import riscv_pkg::*;

  // issue / scoreboard
  logic                iss_valid_i;
  reg_addr_t           iss_rd_addr_i;
  logic                iss_ready_o;
  logic [NUM_REGS-1:0] pending_o;

  // ALU result channel
  logic                alu_valid_i;
  logic                alu_ready_o;
  reg_addr_t           alu_rd_addr_i;
  logic [XLEN-1:0]     alu_data_i;

  // load result channel
  logic                ld_valid_i;
  logic                ld_ready_o;
  reg_addr_t           ld_rd_addr_i;
  logic [2:0]          ld_funct3_i;
  logic [XLEN-1:0]     ld_data_i;

  // register file write port
  reg_addr_t           rd_addr_o;
  logic                wr_en_o;
  logic [XLEN-1:0]     rd_data_o;

  modport slave (
    input  iss_valid_i, iss_rd_addr_i,
    output iss_ready_o, pending_o,
    input  alu_valid_i, alu_rd_addr_i, alu_data_i,
    output alu_ready_o,
    input  ld_valid_i, ld_rd_addr_i, ld_funct3_i, ld_data_i,
    output ld_ready_o,
    output rd_addr_o, wr_en_o, rd_data_o
  );

  modport master (
    output iss_valid_i, iss_rd_addr_i,
    input  iss_ready_o, pending_o,
    output alu_valid_i, alu_rd_addr_i, alu_data_i,
    input  alu_ready_o,
    output ld_valid_i, ld_rd_addr_i, ld_funct3_i, ld_data_i,
    input  ld_ready_o,
    input  rd_addr_o, wr_en_o, rd_data_o
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register outstanding-write counters. Issue increments, a committed
// register-file write decrements; decode stalls when a counter is saturated.
module wb_scoreboard
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_sync_n,
  input  logic                iss_valid_i,
  input  reg_addr_t           iss_rd_addr_i,
  input  logic                commit_en_i,
  input  reg_addr_t           commit_addr_i,
  output logic                iss_ready_o,
  output logic [NUM_REGS-1:0] pending_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_REGS-1:0] full_vec;
  logic                iss_fire;

  // x0 is never tracked
  assign full_vec[0]  = 1'b0;
  assign pending_o[0] = 1'b0;

  assign iss_fire = iss_valid_i && iss_ready_o;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             inc;
    logic             dec;

    assign inc = iss_fire && (iss_rd_addr_i == reg_addr_t'(gi));
    assign dec = commit_en_i && (commit_addr_i == reg_addr_t'(gi));

    // next count: issue and commit in the same cycle cancel; never underflow
    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (dec && !inc && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    // counter register
    always_ff @(posedge clk) begin
      if (!rst_sync_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign pending_o[gi] = (cnt_q != '0);
    assign full_vec[gi]  = (cnt_q == CNT_MAX);
  end

  // issue allowed unless the counter is saturated; a commit to the same
  // register this cycle frees a slot, so it is allowed then too
  always_comb begin
    iss_ready_o = 1'b0;
    if (rst_sync_n) begin
      iss_ready_o = (iss_rd_addr_i == '0) || !full_vec[iss_rd_addr_i] ||
                    (commit_en_i && (commit_addr_i == iss_rd_addr_i));
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: arbitrates load (high priority) against ALU results,
// extends load data, and registers one write per cycle into the register file.
module regfile_writeback
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_sync_n,
  regfile_writeback_if.slave   bus
);

  logic            wr_en_q,   wr_en_d;
  reg_addr_t       rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            ld_acc;
  logic            alu_acc;

  // Sign/zero extension of right-aligned load data; 111 behaves as LD.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (f3)
      LD_B:    r = {{(XLEN-8){d[7]}},   d[7:0]};
      LD_H:    r = {{(XLEN-16){d[15]}}, d[15:0]};
      LD_W:    r = {{(XLEN-32){d[31]}}, d[31:0]};
      LD_BU:   r = {{(XLEN-8){1'b0}},   d[7:0]};
      LD_HU:   r = {{(XLEN-16){1'b0}},  d[15:0]};
      LD_WU:   r = {{(XLEN-32){1'b0}},  d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // load always wins; ALU is only ready when no load is presented
  assign bus.ld_ready_o  = rst_sync_n;
  assign bus.alu_ready_o = rst_sync_n && !bus.ld_valid_i;

  assign ld_acc  = bus.ld_valid_i  && bus.ld_ready_o;
  assign alu_acc = bus.alu_valid_i && bus.alu_ready_o;

  // select the accepted result; x0 results complete the handshake but never write
  always_comb begin
    wr_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (ld_acc) begin
      if (bus.ld_rd_addr_i != '0) begin
        wr_en_d   = 1'b1;
        rd_addr_d = bus.ld_rd_addr_i;
        rd_data_d = load_extend(bus.ld_funct3_i, bus.ld_data_i);
      end
    end else if (alu_acc) begin
      if (bus.alu_rd_addr_i != '0) begin
        wr_en_d   = 1'b1;
        rd_addr_d = bus.alu_rd_addr_i;
        rd_data_d = bus.alu_data_i;
      end
    end
  end

  // registered write port
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.wr_en_o   = wr_en_q;
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.rd_data_o = rd_data_q;

  wb_scoreboard u_scoreboard (
    .clk           (clk),
    .rst_sync_n    (rst_sync_n),
    .iss_valid_i   (bus.iss_valid_i),
    .iss_rd_addr_i (bus.iss_rd_addr_i),
    .commit_en_i   (wr_en_q),
    .commit_addr_i (rd_addr_q),
    .iss_ready_o   (bus.iss_ready_o),
    .pending_o     (bus.pending_o)
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios followed by
// random traffic, all compared against a behavioural model of the stage.
module tb_regfile_writeback;
  import riscv_pkg::*;

  localparam int MAX_OUT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_sync_n;
  always #5 clk = ~clk;

  regfile_writeback_if bus();

  regfile_writeback dut (
    .clk        (clk),
    .rst_sync_n (rst_sync_n),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  // model state: outstanding writes per register and the write expected on the port
  int          exp_cnt[NUM_REGS];
  logic        exp_wr_en;
  logic [4:0]  exp_addr;
  logic [63:0] exp_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // width and signedness taken straight from the funct3 table
  function automatic logic [63:0] ext_ref(input logic [2:0] f3, input logic [63:0] d);
    int w;
    bit sgn;
    logic [63:0] mask;
    logic [63:0] r;
    case (f3)
      3'd0: begin w = 8;  sgn = 1; end
      3'd1: begin w = 16; sgn = 1; end
      3'd2: begin w = 32; sgn = 1; end
      3'd4: begin w = 8;  sgn = 0; end
      3'd5: begin w = 16; sgn = 0; end
      3'd6: begin w = 32; sgn = 0; end
      default: begin w = 64; sgn = 0; end
    endcase
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r = d & mask;
    if (sgn && r[w-1]) r = r | ~mask;
    return r;
  endfunction

  function automatic logic [NUM_REGS-1:0] pending_ref();
    logic [NUM_REGS-1:0] p;
    p = '0;
    for (int r = 1; r < NUM_REGS; r++) p[r] = (exp_cnt[r] != 0);
    return p;
  endfunction

  task automatic reset_for(input int n);
    rst_sync_n        = 1'b0;
    bus.iss_valid_i   = 1'b1; bus.iss_rd_addr_i = 5'd3;
    bus.alu_valid_i   = 1'b1; bus.alu_rd_addr_i = 5'd4; bus.alu_data_i = 64'h55;
    bus.ld_valid_i    = 1'b1; bus.ld_rd_addr_i  = 5'd5; bus.ld_funct3_i = 3'd3;
    bus.ld_data_i     = 64'h66;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst.ld_ready",  {63'd0, bus.ld_ready_o},  64'd0);
      check("rst.alu_ready", {63'd0, bus.alu_ready_o}, 64'd0);
      check("rst.iss_ready", {63'd0, bus.iss_ready_o}, 64'd0);
      @(posedge clk); #1;
      check("rst.wr_en",   {63'd0, bus.wr_en_o}, 64'd0);
      check("rst.rd_addr", {59'd0, bus.rd_addr_o}, 64'd0);
      check("rst.rd_data", bus.rd_data_o, 64'd0);
      check("rst.pending", {32'd0, bus.pending_o}, 64'd0);
    end
    for (int r = 0; r < NUM_REGS; r++) exp_cnt[r] = 0;
    exp_wr_en = 1'b0; exp_addr = '0; exp_data = '0;
    rst_sync_n = 1'b1;
    bus.iss_valid_i = 1'b0; bus.alu_valid_i = 1'b0; bus.ld_valid_i = 1'b0;
  endtask

  // one clock: drive inputs, check handshakes, then check the registered result
  task automatic cycle(input string tag,
                       input logic iv, input logic [4:0] ird,
                       input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [2:0] lf3,
                       input logic [63:0] ldat);
    logic e_alu_rdy;
    logic e_iss_rdy;
    logic committing;
    logic [4:0] commit_addr;
    logic acc;
    logic [4:0] acc_rd;
    logic [63:0] acc_data;
    bus.iss_valid_i = iv; bus.iss_rd_addr_i = ird;
    bus.alu_valid_i = av; bus.alu_rd_addr_i = ard; bus.alu_data_i = ad;
    bus.ld_valid_i  = lv; bus.ld_rd_addr_i  = lrd; bus.ld_funct3_i = lf3;
    bus.ld_data_i   = ldat;
    #1;
    committing  = exp_wr_en;
    commit_addr = exp_addr;
    e_alu_rdy = !lv;
    e_iss_rdy = (ird == 0) || (exp_cnt[ird] < MAX_OUT) || (committing && commit_addr == ird);
    check({tag, ".ld_ready"},  {63'd0, bus.ld_ready_o},  64'd1);
    check({tag, ".alu_ready"}, {63'd0, bus.alu_ready_o}, {63'd0, e_alu_rdy});
    check({tag, ".iss_ready"}, {63'd0, bus.iss_ready_o}, {63'd0, e_iss_rdy});

    acc = 1'b0; acc_rd = '0; acc_data = '0;
    if (lv) begin
      acc = 1'b1; acc_rd = lrd; acc_data = ext_ref(lf3, ldat);
    end else if (av) begin
      acc = 1'b1; acc_rd = ard; acc_data = ad;
    end

    if (iv && e_iss_rdy && ird != 0) exp_cnt[ird]++;
    if (committing && exp_cnt[commit_addr] > 0) exp_cnt[commit_addr]--;

    exp_wr_en = acc && (acc_rd != 0);
    if (exp_wr_en) begin
      exp_addr = acc_rd;
      exp_data = acc_data;
    end

    @(posedge clk); #1;
    $display("cycle %s: wr_en=%0b rd=%0d data=0x%0h pending=0x%0h", tag,
             bus.wr_en_o, bus.rd_addr_o, bus.rd_data_o, bus.pending_o);
    check({tag, ".wr_en"}, {63'd0, bus.wr_en_o}, {63'd0, exp_wr_en});
    // no accepted result: address and data must hold their last value
    if (exp_wr_en || !acc) begin
      check({tag, ".rd_addr"}, {59'd0, bus.rd_addr_o}, {59'd0, exp_addr});
      check({tag, ".rd_data"}, bus.rd_data_o, exp_data);
    end
    check({tag, ".pending"}, {32'd0, bus.pending_o}, {32'd0, pending_ref()});
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 3'd0, 64'd0);
  endtask

  initial begin
    reset_for(3);

    // collision: load wins, ALU result is held and written the next cycle
    cycle("coll0", 0, 0, 1, 5'd6, 64'h1234, 1, 5'd5, 3'd0, 64'h80);
    check("coll0.x5_value", bus.rd_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    cycle("coll1", 0, 0, 1, 5'd6, 64'h1234, 0, 5'd0, 3'd0, 64'd0);
    check("coll1.x6_value", bus.rd_data_o, 64'h1234);
    idle("coll2");

    // extension sweep over every funct3
    for (int f = 0; f < 8; f++) begin
      cycle($sformatf("ext%0d", f), 0, 0, 0, 0, 64'd0, 1, 5'd10, 3'(f),
            64'hFFFF_FFFF_8000_8080);
      if (f == 4) check("ext.lbu", bus.rd_data_o, 64'h80);
      if (f == 1) check("ext.lh",  bus.rd_data_o, 64'hFFFF_FFFF_FFFF_8080);
      if (f == 6) check("ext.lwu", bus.rd_data_o, 64'h8000_8080);
      if (f == 3) check("ext.ld",  bus.rd_data_o, 64'hFFFF_FFFF_8000_8080);
    end
    idle("ext_end");

    // scoreboard saturation on x7, then drain with three ALU writes
    for (int i = 0; i < 3; i++) cycle($sformatf("iss7_%0d", i), 1, 5'd7, 0, 0, 64'd0, 0, 0, 3'd0, 64'd0);
    check("sb.pending7", {63'd0, bus.pending_o[7]}, 64'd1);
    cycle("iss7_full", 1, 5'd7, 0, 0, 64'd0, 0, 0, 3'd0, 64'd0);
    for (int i = 0; i < 3; i++) cycle($sformatf("alu7_%0d", i), 0, 0, 1, 5'd7, 64'(i + 100), 0, 0, 3'd0, 64'd0);
    idle("drain7");
    check("sb.pending7_clear", {63'd0, bus.pending_o[7]}, 64'd0);

    // same-cycle issue and commit to x9
    cycle("x9_iss",  1, 5'd9, 0, 0, 64'd0, 0, 0, 3'd0, 64'd0);
    cycle("x9_alu",  0, 0, 1, 5'd9, 64'h99, 0, 0, 3'd0, 64'd0);
    cycle("x9_both", 1, 5'd9, 0, 0, 64'd0, 0, 0, 3'd0, 64'd0);
    check("sb.pending9", {63'd0, bus.pending_o[9]}, 64'd1);
    cycle("x9_drain", 0, 0, 1, 5'd9, 64'h999, 0, 0, 3'd0, 64'd0);
    idle("x9_end");

    // x0 never writes and is never tracked
    cycle("x0", 1, 5'd0, 1, 5'd0, 64'hDEAD, 0, 0, 3'd0, 64'd0);
    check("x0.wr_en", {63'd0, bus.wr_en_o}, 64'd0);
    idle("x0_end");

    // reset while a write is in flight discards it
    bus.alu_valid_i = 1'b1; bus.alu_rd_addr_i = 5'd3; bus.alu_data_i = 64'h77;
    bus.ld_valid_i = 1'b0; bus.iss_valid_i = 1'b0;
    #1;
    rst_sync_n = 1'b0;
    @(posedge clk); #1;
    check("midrst.wr_en", {63'd0, bus.wr_en_o}, 64'd0);
    reset_for(1);

    // random traffic on a small register window to force collisions
    for (int i = 0; i < 400; i++) begin
      cycle($sformatf("rnd%0d", i),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
